spike_aer_encoder: RTL and testbench
====================================

// Module: spike_aer_encoder
// PURPOSE
//  Downstream consumer of the LIF neuron array's per-neuron spike lines.
//  Latches coincident spikes, serialises them into address events (neuron index + timestamp)
//  by round-robin arbitration, and buffers them in a small FIFO behind a valid/ready port.
//  Lets 8 parallel spike pulses share one narrow output bus without losing simultaneous events.
// PARAMETERS
//  N_NEURONS   8   number of spike inputs
//  ADDR_W      3   event address width, = clog2(N_NEURONS)
//  TS_W        8   timestamp width; free-running counter, wraps
//  FIFO_DEPTH  4   event FIFO entries; power of two
//  DROP_W      8   width of the saturating drop counter
// PORTS
//  clk         in   1          clock
//  rst_n       in   1          asynchronous active-low reset
//  ena         in   1          1 = accept spikes and advance timestamp
//  spike_in    in   N_NEURONS  spike lines from the LIF neurons; level-sampled every cycle
//  ev_valid    out  1          FIFO head holds an event
//  ev_ready    in   1          consumer accepts the head event (pop when valid&ready)
//  ev_addr     out  ADDR_W     neuron index of the head event
//  ev_ts       out  TS_W       timestamp of the head event
//  drop_cnt    out  DROP_W     saturating count of lost spikes
// BEHAVIOUR
//  Reset (async, rst_n=0): pending=0, ts=0, rr_ptr=0, FIFO empty.
//   Outputs: ev_valid=0, ev_addr=0, ev_ts=0, drop_cnt=0.
//  Timestamp: ts += 1 each cycle with ena=1, wraps at 2^TS_W; holds when ena=0.
//  Pending: pending[i] is set at the edge when ena=1 and spike_in[i]=1 (sticky until granted).
//  Arbiter (combinational on pending):
//   - When pending!=0 and the FIFO is not full, grant the first set bit
//     at or after rr_ptr, searching upward with wrap.
//   - On the grant edge: push {addr=i, ts=current ts} into the FIFO, clear pending[i],
//     and set rr_ptr = i+1 (mod N).
//   - Exactly one grant per cycle at most.
//  Simultaneous events:
//   - spike_in[i]=1 in the same cycle pending[i] is granted: pending[i] stays 1; no drop.
//   - spike_in[i]=1 while pending[i]=1 and i not granted: drop_cnt += 1.
//     The counter saturates at 2^DROP_W-1 and adds once per such bit per cycle.
//  Full: no grant while the FIFO is full, even if a pop occurs the same cycle.
//   pending[i] persists, so further spikes on i count as drops.
//  Empty: ev_valid=0; ready is ignored; ev_addr/ev_ts hold their last value.
//  FIFO:
//   - Show-ahead: ev_addr/ev_ts are valid whenever ev_valid=1 and stable while ev_ready=0.
//   - Push and pop in the same cycle (not full, not empty) both take effect.
//  ena=0: no new pending bits and ts frozen; existing pending bits still get granted
//   and the FIFO still drains.
//  Latency: spike_in high before edge E0 -> pending at E0 -> pushed at E1 -> ev_valid=1
//   after E1 (2 cycles minimum, empty FIFO, no contention).
//  Reset mid-operation: all pending and FIFO contents are discarded immediately.
// STRUCTURE
//  snn_pkg: N_NEURONS, ADDR_W, TS_W constants; aer_event_t struct {addr, ts}.
//  Sub-module aer_fifo: synchronous show-ahead FIFO of aer_event_t with full/empty flags.
//  Top level holds the pending register, round-robin arbiter, ts counter and drop counter.
// TESTING
//  1 Reset, then one cycle spike_in=8'h04, ena=1, ev_ready=1.
//    -> ev_valid after 2 edges, ev_addr=2, ev_ts=1; exactly one event.
//  2 One cycle spike_in=8'hFF, ev_ready=1.
//    -> 8 events on consecutive cycles, addr 0..7 in order; drop_cnt=0.
//  3 After an event from neuron 5 (rr_ptr=6), spike_in=8'h21.
//    -> addr 0 before addr 5 (search from 6 wraps to 0).
//  4 ev_ready=0, spike_in=8'hFF held for 6 cycles.
//    -> 4 events buffered, ev_valid=1, head addr=0 stable, drop_cnt>0 and incrementing;
//    -> after ev_ready=1, pending events drain with no duplicates.
//  5 Spike on bit 3 repeated while bit 3 is pending behind full FIFO for 300 cycles.
//    -> drop_cnt saturates at 255.
//  6 Assert rst_n=0 mid-drain with 3 events queued.
//    -> ev_valid=0 and drop_cnt=0 immediately; no event emitted after release
//       without new spikes.

Source files
------------

// File: rtl/spike_aer_encoder_pkg.sv
// Shared constants, the address-event record and a popcount helper for the
// spike-to-AER encoder.
package spike_aer_encoder_pkg;

  localparam int N_NEURONS  = 8;                     // spike input lines
  localparam int ADDR_W     = $clog2(N_NEURONS);     // neuron index width
  localparam int TS_W       = 8;                     // wrapping timestamp width
  localparam int FIFO_DEPTH = 4;                     // event FIFO entries (power of two)
  localparam int DROP_W     = 8;                     // saturating drop counter width
  localparam int CNT_W      = $clog2(N_NEURONS + 1); // holds 0..N_NEURONS

  // One address event: which neuron fired and when it was serialised.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
  } aer_event_t;

  // Number of set bits in a spike-wide vector.
  function automatic logic [CNT_W-1:0] count_ones(input logic [N_NEURONS-1:0] v);
    count_ones = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      count_ones = count_ones + CNT_W'(v[i]);
    end
  endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Address-event output bus: valid/ready handshake carrying one event
// (neuron index + timestamp).
//   master: drives ev_valid, ev_addr, ev_ts; samples ev_ready
//   slave : samples ev_valid, ev_addr, ev_ts; drives ev_ready
interface spike_aer_encoder_if
  import spike_aer_encoder_pkg::*;
();

  logic              ev_valid;
  logic              ev_ready;
  logic [ADDR_W-1:0] ev_addr;
  logic [TS_W-1:0]   ev_ts;

  modport master (output ev_valid, ev_addr, ev_ts, input ev_ready);
  modport slave  (input ev_valid, ev_addr, ev_ts, output ev_ready);

endinterface

// File: rtl/spike_aer_encoder_aer_fifo.sv
// Synchronous show-ahead FIFO of address events.
//   clk, rst_n : clock, asynchronous active-low reset (flushes contents)
//   push_i     : write wr_data_i (ignored when full)
//   wr_data_i  : event to store
//   pop_i      : drop the head entry (ignored when empty)
//   rd_data_o  : head entry while non-empty; last popped entry while empty
//   full_o     : no free entry
//   empty_o    : no stored entry
module aer_fifo
  import spike_aer_encoder_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  aer_event_t wr_data_i,
  input  logic       pop_i,
  output aer_event_t rd_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  aer_event_t     last_q, last_d;
  aer_event_t     mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign last_d   = do_pop  ? mem_q[rd_ptr_q[PTR_W-1:0]] : last_q;

  // While empty the output keeps showing the most recently consumed event.
  assign rd_data_o = empty_o ? last_q : mem_q[rd_ptr_q[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers already
  // makes every entry invalid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: latches per-neuron spike pulses, serialises them with
// a round-robin arbiter into {neuron index, timestamp} events and queues them
// in a small FIFO behind a valid/ready port.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   ena      : accept spikes and advance the timestamp
//   spike_in : level-sampled spike lines, one per neuron
//   drop_cnt : saturating count of spikes lost to an already-pending neuron
//   ev       : event output bus (master side)
module spike_aer_encoder
  import spike_aer_encoder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [N_NEURONS-1:0]      spike_in,
  output logic [DROP_W-1:0]         drop_cnt,
  spike_aer_encoder_if.master       ev
);

  localparam int                SUM_W    = DROP_W + CNT_W;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DROP_W-1:0]    drop_q, drop_d;

  logic                 grant_vld;
  logic [ADDR_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]    cand;
  logic [N_NEURONS-1:0] grant_oh;
  logic [N_NEURONS-1:0] drop_hits;
  logic [SUM_W-1:0]     drop_sum;

  logic       fifo_full;
  logic       fifo_empty;
  aer_event_t fifo_wr;
  aer_event_t fifo_rd;

  // Round-robin search: first pending bit at or after rr_ptr, wrapping.
  // Granting is suppressed while the FIFO is full, even if it pops this cycle.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant_oh  = '0;
    if (!fifo_full) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        cand = ADDR_W'((int'(rr_ptr_q) + k) % N_NEURONS);
        if (!grant_vld && pending_q[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) begin
      grant_oh = N_NEURONS'(1) << grant_idx;
    end
  end

  // Next-state for pending bits, timestamp, pointer and drop counter.
  always_comb begin
    // A spike on the neuron being granted re-arms it rather than being lost.
    pending_d = (pending_q & ~grant_oh) | (ena ? spike_in : '0);
    ts_d      = ena ? ts_q + 1'b1 : ts_q;
    rr_ptr_d  = grant_vld ? ADDR_W'((int'(grant_idx) + 1) % N_NEURONS) : rr_ptr_q;

    // A spike on a neuron that is still waiting has nowhere to go.
    drop_hits = ena ? (spike_in & pending_q & ~grant_oh) : '0;
    drop_sum  = SUM_W'(drop_q) + SUM_W'(count_ones(drop_hits));
    drop_d    = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ts_q      <= '0;
      rr_ptr_q  <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      ts_q      <= ts_d;
      rr_ptr_q  <= rr_ptr_d;
      drop_q    <= drop_d;
    end
  end

  assign fifo_wr = '{addr: grant_idx, ts: ts_q};

  aer_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (grant_vld),
    .wr_data_i (fifo_wr),
    .pop_i     (ev.ev_ready),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_addr  = fifo_rd.addr;
  assign ev.ev_ts    = fifo_rd.ts;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;
  import spike_aer_encoder_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ena = 1'b0;
  logic [N_NEURONS-1:0] spike_in = '0;
  logic [DROP_W-1:0]    drop_cnt;

  spike_aer_encoder_if ev_if ();

  spike_aer_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .spike_in (spike_in),
    .drop_cnt (drop_cnt),
    .ev       (ev_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  aer_event_t exp_q[$];
  aer_event_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int a, input int t);
    exp_q.push_back('{addr: ADDR_W'(a), ts: TS_W'(t)});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ena      = 1'b0;
    spike_in = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    tick(2);
  endtask

  // Monitor: every accepted event is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && ev_if.ev_valid && ev_if.ev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got addr %0d ts %0d, expected none",
                 ev_if.ev_addr, ev_if.ev_ts);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_addr", int'(ev_if.ev_addr), int'(mon_e.addr));
        check("ev_ts", int'(ev_if.ev_ts), int'(mon_e.ts));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  int drops_exp[6] = '{0, 7, 14, 21, 28, 36};

  initial begin
    ev_if.ev_ready = 1'b1;
    do_reset();
    check("rst_valid", int'(ev_if.ev_valid), 0);
    check("rst_addr", int'(ev_if.ev_addr), 0);
    check("rst_ts", int'(ev_if.ev_ts), 0);
    check("rst_drop", int'(drop_cnt), 0);

    // 1: single spike on neuron 2, two-edge latency, timestamp 1
    spike_in = 8'h04; ena = 1'b1;
    expect_ev(2, 1);
    tick();
    spike_in = '0; ena = 1'b0;
    check("t1_valid_e0", int'(ev_if.ev_valid), 0);
    tick();
    check("t1_valid_e1", int'(ev_if.ev_valid), 1);
    check("t1_addr", int'(ev_if.ev_addr), 2);
    check("t1_ts", int'(ev_if.ev_ts), 1);
    tick();
    check("t1_single", int'(ev_if.ev_valid), 0);
    tick(3);
    check("t1_empty", int'(ev_if.ev_valid), 0);
    check("t1_drain", exp_q.size(), 0);

    // 2: all eight neurons at once, served 0..7 on consecutive cycles
    do_reset();
    spike_in = 8'hFF; ena = 1'b1;
    for (int i = 0; i < 8; i++) expect_ev(i, 1);
    tick();
    spike_in = '0; ena = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t2_valid%0d", i), int'(ev_if.ev_valid), 1);
      check($sformatf("t2_head%0d", i), int'(ev_if.ev_addr), i);
    end
    tick();
    check("t2_done", int'(ev_if.ev_valid), 0);
    check("t2_drop", int'(drop_cnt), 0);
    wait_drain("t2_drain", 10);

    // 3: after granting neuron 5 the search starts at 6 and wraps to 0
    spike_in = 8'h20; ena = 1'b1;
    expect_ev(5, 2);
    tick();
    spike_in = '0; ena = 1'b0;
    wait_drain("t3a_drain", 10);
    spike_in = 8'h21; ena = 1'b1;
    expect_ev(0, 3);
    expect_ev(5, 3);
    tick();
    spike_in = '0; ena = 1'b0;
    wait_drain("t3b_drain", 10);

    // 4: consumer stalled, all lines held high for six cycles
    do_reset();
    ev_if.ev_ready = 1'b0;
    spike_in = 8'hFF; ena = 1'b1;
    expect_ev(0, 1); expect_ev(1, 2); expect_ev(2, 3); expect_ev(3, 4);
    for (int i = 4; i < 8; i++) expect_ev(i, 6);
    for (int i = 0; i < 4; i++) expect_ev(i, 6);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t4_drop%0d", i), int'(drop_cnt), drops_exp[i]);
      if (i >= 1) begin
        check($sformatf("t4_valid%0d", i), int'(ev_if.ev_valid), 1);
        check($sformatf("t4_head_addr%0d", i), int'(ev_if.ev_addr), 0);
        check($sformatf("t4_head_ts%0d", i), int'(ev_if.ev_ts), 1);
      end
    end
    spike_in = '0; ena = 1'b0;
    ev_if.ev_ready = 1'b1;
    wait_drain("t4_drain", 40);
    check("t4_idle", int'(ev_if.ev_valid), 0);
    check("t4_drop_final", int'(drop_cnt), 36);

    // 5: neuron 3 pending behind a full FIFO, drop counter saturates
    do_reset();
    ev_if.ev_ready = 1'b0;
    spike_in = 8'h0F; ena = 1'b1;
    for (int i = 0; i < 4; i++) expect_ev(i, 1);
    tick();
    spike_in = '0; ena = 1'b0;
    tick(4);
    spike_in = 8'h08; ena = 1'b1;
    for (int i = 0; i <= 300; i++) begin
      tick();
      if (i == 100) check("t5_drop_mid", int'(drop_cnt), 100);
    end
    check("t5_drop_sat", int'(drop_cnt), 255);
    spike_in = '0; ena = 1'b0;
    expect_ev(3, 46);
    ev_if.ev_ready = 1'b1;
    wait_drain("t5_drain", 20);
    check("t5_drop_hold", int'(drop_cnt), 255);

    // 6: reset while three events are queued
    do_reset();
    ev_if.ev_ready = 1'b0;
    spike_in = 8'h07; ena = 1'b1;
    tick(2);
    spike_in = '0; ena = 1'b0;
    tick(2);
    check("t6_pre_valid", int'(ev_if.ev_valid), 1);
    check("t6_pre_drop", int'(drop_cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(ev_if.ev_valid), 0);
    check("t6_rst_drop", int'(drop_cnt), 0);
    check("t6_rst_addr", int'(ev_if.ev_addr), 0);
    tick(2);
    rst_n = 1'b1;
    ev_if.ev_ready = 1'b1;
    tick(10);
    check("t6_post_valid", int'(ev_if.ev_valid), 0);
    check("t6_post_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
